prefix_adder_compare: RTL and testbench
=======================================

Name: prefix_adder_compare

Overview:
- Registered comparison wrapper around three 8-bit parallel-prefix adders: exact Kogge-Stone, approximate Kogge-Stone and exact Ladner-Fischer.
- Each accepted operand pair yields all three 9-bit sums, the approximation error, and running statistics.
- Sits in the adder characterisation datapath, between the vector source and the result logger.

Parameters:
- APPROX_BITS, 3, number of low-order bits computed approximately in the approximate Kogge-Stone path; legal range 0..7; 0 makes that path exact.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b valid this cycle
- a  input  8  unsigned operand A
- b  input  8  unsigned operand B
- out_valid  output  1  result outputs valid
- sum_ks_exact  output  9  exact Kogge-Stone sum {cout, s[7:0]}
- sum_ks_approx  output  9  approximate Kogge-Stone sum
- sum_lf_exact  output  9  exact Ladner-Fischer sum
- err  output  10  signed two's-complement error: sum_ks_exact minus sum_ks_approx
- vec_count  output  16  number of accepted vectors since reset, saturating
- err_count  output  16  number of accepted vectors with err != 0 since reset, saturating
- exact_mismatch  output  1  sticky flag: sum_ks_exact != sum_lf_exact seen since reset

Behaviour:
- Exact Kogge-Stone:
  - g = a&b, p = a^b.
  - log2 prefix stages at spans 1, 2, 4, combining (G,P)o(G',P') = (G | P&G', P&P').
  - s[i] = p[i] ^ C[i-1], with C[-1] = 0; sum[8] = G[7:0].
- Exact Ladner-Fischer: same g/p; sparse minimum-depth prefix tree (3 stages, fan-out doubling); identical arithmetic result.
- Approximate Kogge-Stone, with k = APPROX_BITS:
  - Low bits i < k: s[i] = a[i] | b[i], no carry chain.
  - Carry into bit k = a[k-1] & b[k-1].
  - Bits k..7 use an exact Kogge-Stone prefix over a[7:k], b[7:k] with that carry-in.
  - sum[8] is the upper carry-out.
  - For k = 0 the path equals exact.
- Combinational adders feed one register stage, so latency is exactly 1 cycle: inputs sampled at edge N appear at edge N+1.
- out_valid(N+1) = in_valid(N). When in_valid = 0, sum/err registers hold their previous values.
- err = zero-extended sum_ks_exact minus zero-extended sum_ks_approx, 10-bit two's complement; range -511..+511.
- On each accepted vector (in_valid = 1):
  - vec_count increments.
  - err_count increments when the combinational err != 0.
  - Both stick at 16'hFFFF.
  - Counters update on the same edge as the result registers.
- exact_mismatch sets when an accepted vector gives differing exact sums; cleared only by rst.
- Reset (rst = 1 at an edge): out_valid = 0; all sums, err, vec_count, err_count = 0; exact_mismatch = 0. Reset has priority over in_valid in the same cycle, and the vector is dropped.
- Reset mid-stream: the next vector after rst deasserts is counted as vector 1.
- Back-to-back in_valid every cycle is supported at full throughput; there is no backpressure.
- Operand wrap: 255+255 = 510 exact, held in 9 bits with no overflow loss.

Test Plan:
- Reset, then a=0, b=0 valid -> next cycle out_valid = 1, all sums 0, err 0, vec_count 1, err_count 0.
- a=200, b=100 -> sum_ks_exact = sum_lf_exact = 300, sum_ks_approx = 300, err 0.
- a=7, b=1 -> exact 8, approx 7, err +1, err_count increments. a=3, b=5 -> exact 8, approx 7, err +1.
- a=255, b=255 -> exact 510, approx 511, err -1 (10'h3FF); exact_mismatch stays 0.
- Stream all 65536 pairs back-to-back:
  - Exact sums equal a+b every cycle and exact_mismatch = 0.
  - vec_count saturates at 65535.
  - Approx matches the bit-level rule above.
- Assert rst mid-stream with in_valid high -> that vector dropped, outputs and counters 0 next cycle, counting resumes from 1.

Source files
------------

// File: rtl/prefix_adder_compare.sv
// Registered comparison of three 8-bit parallel-prefix adders: exact Kogge-Stone,
// approximate Kogge-Stone (low APPROX_BITS bits OR-ed, no carry chain) and exact
// Ladner-Fischer, with error output and running statistics.
module prefix_adder_compare #(
    parameter int unsigned APPROX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [8:0]  sum_ks_exact,
    output logic [8:0]  sum_ks_approx,
    output logic [8:0]  sum_lf_exact,
    output logic [9:0]  err,
    output logic [15:0] vec_count,
    output logic [15:0] err_count,
    output logic        exact_mismatch
);

    localparam int K = int'(APPROX_BITS);

    // Kogge-Stone prefix: spans 1, 2, 4; returns group generate G[i:0] per bit.
    function automatic logic [7:0] ks_prefix(input logic [7:0] g, input logic [7:0] p);
        logic [7:0] gg, pp, gn, pn;
        gg = g;
        pp = p;
        for (int s = 1; s < 8; s = s * 2) begin
            gn = gg;
            pn = pp;
            for (int i = s; i < 8; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-s]);
                pn[i] = pp[i] & pp[i-s];
            end
            gg = gn;
            pp = pn;
        end
        return gg;
    endfunction

    logic [7:0] g, p;
    logic [7:0] c_ks, c_ap, c_lf;
    logic [7:0] g_ap, p_ap;
    logic [8:0] ks_sum, ap_sum, lf_sum;
    logic [9:0] err_comb;

    // Exact Kogge-Stone sum.
    always_comb begin
        g      = a & b;
        p      = a ^ b;
        c_ks   = ks_prefix(g, p);
        ks_sum = '0;
        ks_sum[0] = p[0];
        for (int i = 1; i < 8; i++) ks_sum[i] = p[i] ^ c_ks[i-1];
        ks_sum[8] = c_ks[7];
    end

    // Approximate Kogge-Stone: masking the low bits to (g=0,p=0), except bit K-1
    // which keeps its generate, makes the carry into bit K equal a[K-1]&b[K-1]
    // and lets one full-width prefix serve the exact upper part.
    always_comb begin
        g_ap = g;
        p_ap = p;
        for (int i = 0; i < 8; i++) begin
            if (i < K) begin
                g_ap[i] = (i == K - 1) ? g[i] : 1'b0;
                p_ap[i] = 1'b0;
            end
        end
        c_ap   = ks_prefix(g_ap, p_ap);
        ap_sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < K)       ap_sum[i] = a[i] | b[i];
            else if (i == 0) ap_sum[i] = p[i];
            else             ap_sum[i] = p[i] ^ c_ap[i-1];
        end
        ap_sum[8] = c_ap[7];
    end

    // Ladner-Fischer: 3 sparse stages, fan-out doubling (1, 2, 4).
    always_comb begin
        logic [7:0] g1, p1, g2, p2;
        g1 = g;
        p1 = p;
        for (int i = 1; i < 8; i += 2) begin
            g1[i] = g[i] | (p[i] & g[i-1]);
            p1[i] = p[i] & p[i-1];
        end
        g2 = g1;
        p2 = p1;
        for (int i = 2; i < 4; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[1]);
            p2[i] = p1[i] & p1[1];
        end
        for (int i = 6; i < 8; i++) begin
            g2[i] = g1[i] | (p1[i] & g1[5]);
            p2[i] = p1[i] & p1[5];
        end
        c_lf = g2;
        for (int i = 4; i < 8; i++) c_lf[i] = g2[i] | (p2[i] & g2[3]);
        lf_sum = '0;
        lf_sum[0] = p[0];
        for (int i = 1; i < 8; i++) lf_sum[i] = p[i] ^ c_lf[i-1];
        lf_sum[8] = c_lf[7];
    end

    // Signed error of the approximate path against the exact one.
    always_comb begin
        err_comb = {1'b0, ks_sum} - {1'b0, ap_sum};
    end

    // Result registers and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            sum_ks_exact   <= '0;
            sum_ks_approx  <= '0;
            sum_lf_exact   <= '0;
            err            <= '0;
            vec_count      <= '0;
            err_count      <= '0;
            exact_mismatch <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_ks_exact  <= ks_sum;
                sum_ks_approx <= ap_sum;
                sum_lf_exact  <= lf_sum;
                err           <= err_comb;
                if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
                if (err_comb != '0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (ks_sum != lf_sum) exact_mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prefix_adder_compare.sv
// Self-checking bench for prefix_adder_compare: directed cases, random traffic with
// sporadic resets, a full back-to-back operand sweep, and mid-stream reset.
module tb_prefix_adder_compare;

    localparam int unsigned K = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a, b;
    logic        out_valid;
    logic [8:0]  sum_ks_exact, sum_ks_approx, sum_lf_exact;
    logic [9:0]  err;
    logic [15:0] vec_count, err_count;
    logic        exact_mismatch;

    prefix_adder_compare #(.APPROX_BITS(K)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .sum_ks_exact   (sum_ks_exact),
        .sum_ks_approx  (sum_ks_approx),
        .sum_lf_exact   (sum_lf_exact),
        .err            (err),
        .vec_count      (vec_count),
        .err_count      (err_count),
        .exact_mismatch (exact_mismatch)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state (what the outputs should show after the last edge).
    logic       m_valid;
    int         m_ex, m_ap, m_vec, m_errc;
    logic [9:0] m_err;
    logic       m_mis;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Approximate sum from the rule: OR the low K bits, add the upper slices with
    // carry-in a[K-1]&b[K-1].
    function automatic int ref_approx(input int x, input int y);
        int low, cin, hi;
        if (K == 0) return x + y;
        low = (x | y) & ((1 << K) - 1);
        cin = ((x >> (K - 1)) & (y >> (K - 1))) & 1;
        hi  = (x >> K) + (y >> K) + cin;
        return (hi << K) | low;
    endfunction

    task automatic check_all();
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("sum_ks_exact", 32'(sum_ks_exact), 32'(m_ex));
        check_eq("sum_lf_exact", 32'(sum_lf_exact), 32'(m_ex));
        check_eq("sum_ks_approx", 32'(sum_ks_approx), 32'(m_ap));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("vec_count", 32'(vec_count), 32'(m_vec));
        check_eq("err_count", 32'(err_count), 32'(m_errc));
        check_eq("exact_mismatch", 32'(exact_mismatch), 32'(m_mis));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input logic r, input logic v, input logic [7:0] ta, input logic [7:0] tb_v);
        int ex, ap;
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb_v;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_ex = 0; m_ap = 0; m_err = '0;
            m_vec = 0; m_errc = 0; m_mis = 0;
        end else begin
            m_valid = v;
            if (v) begin
                ex    = int'(ta) + int'(tb_v);
                ap    = ref_approx(int'(ta), int'(tb_v));
                m_ex  = ex;
                m_ap  = ap;
                m_err = 10'(ex - ap);
                if (m_vec < 65535) m_vec++;
                if (ex != ap && m_errc < 65535) m_errc++;
            end
        end
        check_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        step(1, 0, 0, 0);
        step(1, 1, 8'd9, 8'd9);

        // Directed cases.
        step(0, 1, 8'd0, 8'd0);
        step(0, 1, 8'd200, 8'd100);
        check_eq("dir_200_100_exact", 32'(sum_ks_exact), 32'd300);
        check_eq("dir_200_100_approx", 32'(sum_ks_approx), 32'd300);
        step(0, 1, 8'd7, 8'd1);
        check_eq("dir_7_1_approx", 32'(sum_ks_approx), 32'd7);
        check_eq("dir_7_1_err", 32'(err), 32'd1);
        step(0, 1, 8'd3, 8'd5);
        check_eq("dir_3_5_err", 32'(err), 32'd1);
        step(0, 1, 8'd255, 8'd255);
        check_eq("dir_255_255_exact", 32'(sum_ks_exact), 32'd510);
        check_eq("dir_255_255_approx", 32'(sum_ks_approx), 32'd511);
        check_eq("dir_255_255_err", 32'(err), 32'h3FF);
        step(0, 0, 8'd1, 8'd1);
        step(0, 0, 8'd2, 8'd2);

        // Random traffic with idle cycles and occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom));
        end

        // Full back-to-back sweep from reset; vec_count ends saturated.
        step(1, 0, 0, 0);
        for (int i = 0; i < 65536; i++) begin
            step(0, 1, 8'(i >> 8), 8'(i));
        end
        check_eq("sweep_vec_sat", 32'(vec_count), 32'hFFFF);
        check_eq("sweep_no_mismatch", 32'(exact_mismatch), 32'd0);

        // Reset with in_valid high drops the vector; counting restarts at 1.
        step(0, 1, 8'd7, 8'd1);
        step(1, 1, 8'd3, 8'd5);
        check_eq("midrst_vec", 32'(vec_count), 32'd0);
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        step(0, 1, 8'd3, 8'd5);
        check_eq("after_rst_vec", 32'(vec_count), 32'd1);
        check_eq("after_rst_errc", 32'(err_count), 32'd1);
        step(0, 0, 8'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
